// File: rtl/eff_echo.sv
// Feedback echo stage: each accepted sample is mixed with a delayed copy of the
// stage's own feedback signal held in a circular buffer that is cleared after reset.
module eff_echo #(
  parameter int W      = 24,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] dly,
  input  logic [3:0]        fb,
  input  logic [3:0]        mix,
  input  logic [W-1:0]      data_i,
  input  logic              vld_i,
  output logic [W-1:0]      data_o,
  output logic              vld_o,
  output logic              busy,
  output logic              ovf
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int PW = W + 5;
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {CLR, IDLE, RD, MAC, WR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     dly_q, dly_d;
  logic [3:0]            fb_q, fb_d;
  logic [3:0]            mix_q, mix_d;
  logic                  en_q, en_d;
  logic signed [W-1:0]   x_q, x_d;
  logic signed [W-1:0]   b_q, b_d;
  logic signed [W-1:0]   data_o_q, data_o_d;
  logic                  vld_o_q, vld_o_d;
  logic                  ovf_q, ovf_d;

  logic [W-1:0]          mem [DEPTH];
  logic [W-1:0]          rd_data_q;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [W-1:0]          mem_wdata;

  logic signed [W-1:0]   d;
  logic signed [PW-1:0]  wet, fbk, y_full, b_full;

  function automatic logic signed [W-1:0] sat(input logic signed [PW-1:0] v);
    if (v > PW'(SMAX))      return SMAX;
    else if (v < PW'(SMIN)) return SMIN;
    else                    return v[W-1:0];
  endfunction

  // Echo off (dly = 0) or dry bypass both replace the delayed sample with zero.
  always_comb begin
    d      = (en_q && dly_q != '0) ? $signed(rd_data_q) : '0;
    wet    = (PW'(d) * PW'($signed({1'b0, mix_q}))) >>> 3;
    fbk    = (PW'(d) * PW'($signed({1'b0, fb_q}))) >>> 3;
    y_full = PW'(x_q) + wet;
    b_full = PW'(x_q) + fbk;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = wr_ptr_q;
    mem_wdata = b_q;
    case (state_q)
      CLR: begin
        mem_we    = !rst;
        mem_addr  = clr_cnt_q;
        mem_wdata = '0;
      end
      RD:      mem_addr = wr_ptr_q - dly_q;
      WR:      mem_we   = !rst;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    rd_data_q <= mem[mem_addr];
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    dly_d     = dly_q;
    fb_d      = fb_q;
    mix_d     = mix_q;
    en_d      = en_q;
    x_d       = x_q;
    b_d       = b_q;
    data_o_d  = data_o_q;
    vld_o_d   = 1'b0;
    ovf_d     = ovf_q;
    if (vld_i && state_q != IDLE) ovf_d = 1'b1;
    case (state_q)
      CLR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
        end
      end
      IDLE: begin
        if (vld_i) begin
          x_d     = $signed(data_i);
          dly_d   = dly;
          fb_d    = (fb > 4'd8) ? 4'd8 : fb;
          mix_d   = (mix > 4'd8) ? 4'd8 : mix;
          en_d    = en;
          state_d = RD;
        end
      end
      RD:  state_d = MAC;
      MAC: begin
        data_o_d = sat(y_full);
        b_d      = sat(b_full);
        vld_o_d  = 1'b1;
        state_d  = WR;
      end
      WR: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = CLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLR;
      clr_cnt_q <= '0;
      wr_ptr_q  <= '0;
      dly_q     <= '0;
      fb_q      <= '0;
      mix_q     <= '0;
      en_q      <= 1'b0;
      x_q       <= '0;
      b_q       <= '0;
      data_o_q  <= '0;
      vld_o_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      dly_q     <= dly_d;
      fb_q      <= fb_d;
      mix_q     <= mix_d;
      en_q      <= en_d;
      x_q       <= x_d;
      b_q       <= b_d;
      data_o_q  <= data_o_d;
      vld_o_q   <= vld_o_d;
      ovf_q     <= ovf_d;
    end
  end

  assign data_o = data_o_q;
  assign vld_o  = vld_o_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_eff_echo.sv
// Bench for eff_echo with a 16-entry buffer: constant vectors for the documented
// sequences plus randomized traffic checked against a sample-history echo model.
module tb_eff_echo;
  localparam int W = 24;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [ADDR_W-1:0] dly;
  logic [3:0]        fb, mix;
  logic [W-1:0]      data_i;
  logic              vld_i;
  logic [W-1:0]      data_o;
  logic              vld_o, busy, ovf;

  eff_echo #(.W(W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .en(en), .dly(dly), .fb(fb), .mix(mix),
    .data_i(data_i), .vld_i(vld_i), .data_o(data_o), .vld_o(vld_o),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  longint b_hist[$];

  typedef struct {
    bit     rst_first;
    bit     en;
    int     dly;
    int     fb;
    int     mix;
    longint x;
    longint exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic longint sat(input longint v);
    longint hi = (64'sd1 <<< (W - 1)) - 1;
    longint lo = -(64'sd1 <<< (W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint floor_div8(input longint p);
    if (p >= 0) return p / 8;
    return -((-p + 7) / 8);
  endfunction

  // Output k echoes the feedback value stored for sample k-dly since the last clear.
  function automatic longint model_step(input longint x, input bit e, input int dl,
                                        input int f, input int m);
    int     k = b_hist.size();
    longint d = 0;
    int     fc = (f > 8) ? 8 : f;
    int     mc = (m > 8) ? 8 : m;
    longint y;
    if (e && dl != 0 && k >= dl) d = b_hist[k - dl];
    y = sat(x + floor_div8(d * mc));
    b_hist.push_back(sat(x + floor_div8(d * fc)));
    return y;
  endfunction

  function automatic longint rand24();
    logic signed [W-1:0] v;
    v = W'($urandom);
    return v;
  endfunction

  task automatic set_params(input bit e, input int dl, input int f, input int m);
    en  = e;
    dly = ADDR_W'(dl);
    fb  = 4'(f);
    mix = 4'(m);
  endtask

  task automatic wait_clear(input string name);
    int n = 0;
    int seen = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
      if (vld_o) seen++;
    end
    chk({name, "_clr_len"}, n, 16);
    chk({name, "_clr_no_vld"}, seen, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_ovf", ovf, 0);
    chk("reset_busy", busy, 1);
    chk("reset_vld_o", vld_o, 0);
    chk("reset_data_o", $signed(data_o), 0);
    rst = 1'b0;
    wait_clear("reset");
    b_hist.delete();
  endtask

  task automatic run(input string name, input longint x, input longint exp);
    logic signed [W-1:0] y;
    int   lat;
    logic bz;
    data_i = x[W-1:0];
    vld_i  = 1'b1;
    @(posedge clk); #1;
    vld_i = 1'b0;
    bz  = busy;
    lat = 1;
    while (!vld_o && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    y = data_o;
    @(posedge clk); #1;
    chk({name, "_data"}, y, exp);
    chk({name, "_lat"}, lat, 3);
    chk({name, "_busy"}, bz, 1);
    chk({name, "_pulse"}, vld_o, 0);
    chk({name, "_hold"}, $signed(data_o), exp);
    chk({name, "_idle"}, busy, 0);
  endtask

  function automatic void add(input bit r, input bit e, input int dl, input int f,
                              input int m, input longint x, input longint exp);
    vec_t v;
    v.rst_first = r; v.en = e; v.dly = dl; v.fb = f; v.mix = m; v.x = x; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint x, y, a;
    int     seen;
    rst = 1'b1; vld_i = 1'b0; data_i = '0;
    set_params(1'b1, 0, 0, 0);

    // Reset release with a strobe dropped mid-sweep.
    repeat (3) @(posedge clk);
    #1;
    chk("por_vld_o", vld_o, 0);
    chk("por_data_o", $signed(data_o), 0);
    chk("por_ovf", ovf, 0);
    chk("por_busy", busy, 1);
    rst = 1'b0;
    begin
      int n = 0;
      seen = 0;
      while (busy && n < 100) begin
        n++;
        vld_i = (n == 5);
        @(posedge clk); #1;
        if (vld_o) seen++;
      end
      vld_i = 1'b0;
      chk("clr_len", n, 16);
    end
    chk("clr_no_vld_o", seen, 0);
    chk("clr_drop_ovf", ovf, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("clr_drop_no_out", vld_o, 0);
    do_reset();

    // Impulse and saturation vectors.
    add(1, 1, 3, 4, 8, 8000, 8000);
    add(0, 1, 3, 4, 8, 0, 0);
    add(0, 1, 3, 4, 8, 0, 0);
    add(0, 1, 3, 4, 8, 0, 8000);
    add(0, 1, 3, 4, 8, 0, 0);
    add(0, 1, 3, 4, 8, 0, 0);
    add(0, 1, 3, 4, 8, 0, 4000);
    add(0, 1, 3, 4, 8, 0, 0);
    add(0, 1, 3, 4, 8, 0, 0);
    add(0, 1, 3, 4, 8, 0, 2000);
    add(1, 1, 1, 8, 8, 64'sh600000, 64'sh600000);
    add(0, 1, 1, 8, 8, 64'sh600000, 64'sh7FFFFF);
    add(1, 1, 1, 8, 8, -64'sh600000, -64'sh600000);
    add(0, 1, 1, 8, 8, -64'sh600000, -64'sh800000);
    add(1, 1, 1, 15, 12, 100, 100);
    add(0, 1, 1, 15, 12, 0, 100);
    add(0, 1, 1, 15, 12, 0, 100);
    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      set_params(vecs[i].en, vecs[i].dly, vecs[i].fb, vecs[i].mix);
      a = model_step(vecs[i].x, vecs[i].en, vecs[i].dly, vecs[i].fb, vecs[i].mix);
      run($sformatf("vec%0d", i), vecs[i].x, vecs[i].exp);
    end

    // Bypass then enable: echoes come from samples written while bypassed.
    do_reset();
    set_params(1'b0, 2, 8, 8);
    for (int i = 0; i < 20; i++) begin
      x = rand24();
      y = model_step(x, 1'b0, 2, 8, 8);
      run("bypass", x, x);
    end
    set_params(1'b1, 2, 0, 8);
    for (int i = 0; i < 10; i++) begin
      x = rand24() >>> 2;
      y = model_step(x, 1'b1, 2, 0, 8);
      run("bypass_echo", x, y);
    end

    // Maximum delay across the pointer wrap, then delay zero.
    do_reset();
    set_params(1'b1, 15, 4, 8);
    for (int k = 0; k < 40; k++) begin
      x = (k + 1) * 1000;
      y = model_step(x, 1'b1, 15, 4, 8);
      run("wrap", x, y);
    end
    set_params(1'b1, 0, 8, 8);
    for (int k = 0; k < 5; k++) begin
      x = rand24();
      y = model_step(x, 1'b1, 0, 8, 8);
      run("dly0", x, x);
    end

    // Randomized parameters against the model.
    for (int k = 0; k < 60; k++) begin
      bit e  = ($urandom_range(0, 3) != 0);
      int dl = $urandom_range(0, 15);
      int f  = $urandom_range(0, 15);
      int m  = $urandom_range(0, 15);
      x = ($urandom_range(0, 1) != 0) ? rand24() : (rand24() >>> 8);
      set_params(e, dl, f, m);
      y = model_step(x, e, dl, f, m);
      run("rand", x, y);
    end

    // Back-to-back strobes: second is dropped.
    do_reset();
    set_params(1'b1, 1, 4, 8);
    y = model_step(1234, 1'b1, 1, 4, 8);
    run("b2b_pre", 1234, y);
    y = model_step(-5000, 1'b1, 1, 4, 8);
    data_i = W'(-5000);
    vld_i = 1'b1;
    @(posedge clk); #1;
    vld_i = 1'b0;
    @(posedge clk); #1;
    data_i = W'(777);
    vld_i = 1'b1;
    @(posedge clk); #1;
    vld_i = 1'b0;
    chk("b2b_vld_o", vld_o, 1);
    chk("b2b_data", $signed(data_o), y);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (vld_o) seen++;
    end
    chk("b2b_single_out", seen, 0);
    chk("b2b_ovf", ovf, 1);
    y = model_step(300, 1'b1, 1, 4, 8);
    run("b2b_post", 300, y);
    chk("b2b_ovf_sticky", ovf, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
